// File: rtl/dma_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : dma_pkg
//  Purpose  : Shared types and constants for the RX read-command path.
//             Holds the controller state encoding, the read line size and
//             the width of the per-transfer line counter.
//  Revision : 1.0 - initial release
// ============================================================================
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int LINE_BYTES = 128;
    localparam int LINE_SHIFT = 7;
    localparam int LINES_W    = 26;

    // Number of 128-byte lines touched by a transfer starting at byte
    // 'offset' inside its first line. The sum needs 33 bits so that a
    // maximal size plus offset plus rounding cannot overflow.
    function automatic logic [LINES_W-1:0] calc_lines(
        input logic [6:0]  offset,
        input logic [31:0] size
    );
        return LINES_W'((33'(offset) + 33'(size) + 33'(LINE_BYTES - 1)) >> LINE_SHIFT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_read_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : rx_read_ctrl_if
//  Purpose  : Bundles the descriptor, read-command, credit and aligner
//             signals of rx_read_ctrl.
//  Ports    : desc_val_i/desc_rdy_o/desc_addr_i/desc_size_i - descriptor
//             offset_o/rx_size_o                           - to aligner
//             cmd_val_o/cmd_addr_o/cmd_tag_o               - read commands
//             credit_i                                     - credit return
//             align_eop_i                                  - aligner EOP
//             busy_o/done_o/err_o                          - status
//  Revision : 1.0 - initial release
// ============================================================================
interface rx_read_ctrl_if #(
    parameter int TAG_W = 8
);
    logic             desc_val_i;
    logic             desc_rdy_o;
    logic [0:63]      desc_addr_i;
    logic [0:31]      desc_size_i;
    logic [0:6]       offset_o;
    logic [0:31]      rx_size_o;
    logic             cmd_val_o;
    logic [0:63]      cmd_addr_o;
    logic [0:TAG_W-1] cmd_tag_o;
    logic             credit_i;
    logic             align_eop_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    modport master (
        output desc_val_i, desc_addr_i, desc_size_i, credit_i, align_eop_i,
        input  desc_rdy_o, offset_o, rx_size_o, cmd_val_o, cmd_addr_o,
               cmd_tag_o, busy_o, done_o, err_o
    );

    modport slave (
        input  desc_val_i, desc_addr_i, desc_size_i, credit_i, align_eop_i,
        output desc_rdy_o, offset_o, rx_size_o, cmd_val_o, cmd_addr_o,
               cmd_tag_o, busy_o, done_o, err_o
    );
endinterface

`default_nettype wire

// File: rtl/credit_cnt.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : credit_cnt
//  Purpose  : Outstanding read-command credit counter. Starts full, one
//             credit consumed per take, one returned per give. A give with
//             the counter already full is dropped and latches err.
//  Ports    : clk, reset (sync, active-high), take, give -> avail, err
//  Revision : 1.0 - initial release
// ============================================================================
module credit_cnt #(
    parameter int CREDITS = 8
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic take,
    input  wire logic give,
    output logic      avail,
    output logic      err
);
    localparam int              c_CW   = $clog2(CREDITS + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(CREDITS);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [c_CW-1:0] r_count;
    logic            r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= c_FULL;
            r_err   <= 1'b0;
        end else begin
            case ({take, give})
                2'b10: begin
                    if (r_count != '0) begin
                        r_count <= r_count - c_ONE;
                    end
                end
                2'b01: begin
                    if (r_count == c_FULL) begin
                        r_err <= 1'b1;
                    end else begin
                        r_count <= r_count + c_ONE;
                    end
                end
                default: begin
                    // Both or neither: net change is zero.
                end
            endcase
        end
    end

    assign avail = (r_count != '0);
    assign err   = r_err;

endmodule

`default_nettype wire

// File: rtl/rx_read_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : rx_read_ctrl
//  Purpose  : Splits a transfer descriptor into 128-byte aligned read
//             commands, paced by returned credits, then waits for the
//             aligner end-of-packet before signalling completion.
//  Ports    : clk, reset (sync, active-high)
//             bus (rx_read_ctrl_if.slave) - descriptor, command, credit,
//             aligner and status signals
//  Revision : 1.0 - initial release
// ============================================================================
module rx_read_ctrl
    import dma_pkg::*;
#(
    parameter int CREDITS = 8,
    parameter int TAG_W   = 8
) (
    input  wire logic     clk,
    input  wire logic     reset,
    rx_read_ctrl_if.slave bus
);
    state_t             r_state;
    state_t             w_state_nxt;
    logic [0:6]         r_offset;
    logic [0:31]        r_size;
    logic [0:63]        r_addr;
    logic [0:TAG_W-1]   r_tag;
    logic [LINES_W-1:0] r_lines;

    logic w_accept;
    logic w_issue;
    logic w_avail;
    logic w_err;

    credit_cnt #(
        .CREDITS (CREDITS)
    ) u_credit_cnt (
        .clk   (clk),
        .reset (reset),
        .take  (w_issue),
        .give  (bus.credit_i),
        .avail (w_avail),
        .err   (w_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = bus.desc_val_i;
                if (bus.desc_val_i) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_issue = w_avail;
                // r_lines counts lines still to issue, including this one.
                if (w_avail && (r_lines <= LINES_W'(1))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.align_eop_i) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_offset <= '0;
            r_size   <= '0;
            r_addr   <= '0;
            r_tag    <= '0;
            r_lines  <= '0;
        end else if (w_accept) begin
            r_offset <= bus.desc_addr_i[57:63];
            r_size   <= bus.desc_size_i;
            r_addr   <= {bus.desc_addr_i[0:56], 7'b0};
            r_tag    <= '0;
            r_lines  <= calc_lines(bus.desc_addr_i[57:63], bus.desc_size_i);
        end else if (w_issue) begin
            // Address and tag both wrap naturally at their widths.
            r_addr  <= r_addr + 64'(LINE_BYTES);
            r_tag   <= r_tag + TAG_W'(1);
            r_lines <= r_lines - LINES_W'(1);
        end
    end

    assign bus.desc_rdy_o = (r_state == ST_IDLE);
    assign bus.busy_o     = (r_state != ST_IDLE);
    assign bus.done_o     = (r_state == ST_DONE);
    assign bus.cmd_val_o  = w_issue;
    assign bus.cmd_addr_o = r_addr;
    assign bus.cmd_tag_o  = r_tag;
    assign bus.offset_o   = r_offset;
    assign bus.rx_size_o  = r_size;
    assign bus.err_o      = w_err;

endmodule

`default_nettype wire
